// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: pipeline hazard controller for the 5-stage RV32 core.
// Resolves load-use stalls, taken-branch flushes and data-memory wait freezes,
// runs a memory-wait watchdog and keeps saturating performance counters.
module hazard_stall_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RS1_2,
  input  logic [4:0]       RS2_2,
  input  logic             Uses_RS2_2,
  input  logic [4:0]       RD_3,
  input  logic             Mem_Read_3,
  input  logic             Branch_Taken_3,
  input  logic             Mem_Req_4,
  input  logic             Mem_Ready_4,
  input  logic             Err_Clear,
  input  logic             Perf_Clear,
  output logic             Stall_PC,
  output logic             Stall_1,
  output logic             Bubble_3,
  output logic             Flush_2,
  output logic             Freeze,
  output logic             Mem_Timeout,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count,
  output logic [CNT_W-1:0] Freeze_Count
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_WAIT  = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic [CNT_W-1:0] freeze_count_q, freeze_count_d;

  logic load_use;
  logic mem_wait;
  logic wait_done;

  // Hazard detection terms; a dropped request while waiting counts as done.
  always_comb begin
    load_use  = Mem_Read_3 && (RD_3 != 5'd0) &&
                ((RD_3 == RS1_2) || (Uses_RS2_2 && (RD_3 == RS2_2)));
    mem_wait  = Mem_Req_4 && !Mem_Ready_4;
    wait_done = Mem_Ready_4 || !Mem_Req_4;
  end

  // Control outputs: Freeze beats branch flush beats load-use, all forced low in reset.
  always_comb begin
    Stall_PC = 1'b0;
    Stall_1  = 1'b0;
    Bubble_3 = 1'b0;
    Flush_2  = 1'b0;
    Freeze   = 1'b0;
    if (!rst) begin
      unique case (state_q)
        S_RUN:   Freeze = mem_wait;
        S_WAIT:  Freeze = !wait_done;
        S_ERROR: Freeze = 1'b1;
        default: Freeze = 1'b0;
      endcase
      if (!Freeze) begin
        if (Branch_Taken_3) begin
          Flush_2  = 1'b1;
          Bubble_3 = 1'b1;
        end else if (load_use) begin
          Stall_PC = 1'b1;
          Stall_1  = 1'b1;
          Bubble_3 = 1'b1;
        end
      end
    end
  end

  // Memory-wait FSM with watchdog counter and sticky timeout flag.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    unique case (state_q)
      S_RUN: begin
        if (mem_wait) begin
          state_d    = S_WAIT;
          wait_cnt_d = CNT_ONE;
        end else begin
          wait_cnt_d = '0;
        end
      end
      S_WAIT: begin
        if (wait_done) begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_ONE;
          if (wait_cnt_d == CNT_TO) begin
            state_d       = S_ERROR;
            mem_timeout_d = 1'b1;
          end
        end
      end
      S_ERROR: begin
        if (Err_Clear) begin
          state_d       = S_RUN;
          wait_cnt_d    = '0;
          mem_timeout_d = 1'b0;
        end
      end
      default: begin
        state_d    = S_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Saturating event counters; a clear wins over a same-cycle increment.
  always_comb begin
    stall_count_d  = stall_count_q;
    flush_count_d  = flush_count_q;
    freeze_count_d = freeze_count_q;
    if (Perf_Clear) begin
      stall_count_d  = '0;
      flush_count_d  = '0;
      freeze_count_d = '0;
    end else begin
      if (Stall_PC && (stall_count_q != CNT_MAX))
        stall_count_d = stall_count_q + CNT_ONE;
      if (Flush_2 && (flush_count_q != CNT_MAX))
        flush_count_d = flush_count_q + CNT_ONE;
      if (Freeze && (freeze_count_q != CNT_MAX))
        freeze_count_d = freeze_count_q + CNT_ONE;
    end
  end

  // State and counter registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_RUN;
      wait_cnt_q     <= '0;
      mem_timeout_q  <= 1'b0;
      stall_count_q  <= '0;
      flush_count_q  <= '0;
      freeze_count_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_count_q  <= stall_count_d;
      flush_count_q  <= flush_count_d;
      freeze_count_q <= freeze_count_d;
    end
  end

  assign Mem_Timeout  = mem_timeout_q;
  assign Stall_Count  = stall_count_q;
  assign Flush_Count  = flush_count_q;
  assign Freeze_Count = freeze_count_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Testbench for hazard_stall_unit: directed vectors with hand-computed
// expectations queued by the stimulus and popped by a negedge monitor.
module tb_hazard_stall_unit;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  typedef struct {
    string            name;
    logic [4:0]       ctl;
    logic             timeout;
    logic             chk_cnt;
    logic [CNT_W-1:0] stall_c;
    logic [CNT_W-1:0] flush_c;
    logic [CNT_W-1:0] freeze_c;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [4:0]       rs1_2 = '0;
  logic [4:0]       rs2_2 = '0;
  logic             uses_rs2_2 = 1'b0;
  logic [4:0]       rd_3 = '0;
  logic             mem_read_3 = 1'b0;
  logic             branch_taken_3 = 1'b0;
  logic             mem_req_4 = 1'b0;
  logic             mem_ready_4 = 1'b0;
  logic             err_clear = 1'b0;
  logic             perf_clear = 1'b0;
  logic             stall_pc, stall_1, bubble_3, flush_2, freeze, mem_timeout;
  logic [CNT_W-1:0] stall_count, flush_count, freeze_count;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  hazard_stall_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .RS1_2(rs1_2), .RS2_2(rs2_2), .Uses_RS2_2(uses_rs2_2),
    .RD_3(rd_3), .Mem_Read_3(mem_read_3), .Branch_Taken_3(branch_taken_3),
    .Mem_Req_4(mem_req_4), .Mem_Ready_4(mem_ready_4),
    .Err_Clear(err_clear), .Perf_Clear(perf_clear),
    .Stall_PC(stall_pc), .Stall_1(stall_1), .Bubble_3(bubble_3),
    .Flush_2(flush_2), .Freeze(freeze), .Mem_Timeout(mem_timeout),
    .Stall_Count(stall_count), .Flush_Count(flush_count), .Freeze_Count(freeze_count)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the rising edge and queue its expectation.
  // ctl order is {Stall_PC, Stall_1, Bubble_3, Flush_2, Freeze}; counts are the
  // values visible during this cycle, before its closing edge.
  task automatic applyStimulus(
    input string name, input logic r,
    input logic [4:0] rs1, input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
    input logic mr, input logic br, input logic req, input logic rdy,
    input logic ec, input logic pc,
    input logic [4:0] ctl, input logic to, input logic chk,
    input int sc, input int fc, input int zc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; rs1_2 = rs1; rs2_2 = rs2; uses_rs2_2 = u2; rd_3 = rd;
    mem_read_3 = mr; branch_taken_3 = br; mem_req_4 = req; mem_ready_4 = rdy;
    err_clear = ec; perf_clear = pc;
    e.name = name; e.ctl = ctl; e.timeout = to; e.chk_cnt = chk;
    e.stall_c = CNT_W'(sc); e.flush_c = CNT_W'(fc); e.freeze_c = CNT_W'(zc);
    exp_q.push_back(e);
  endtask

  // Compare the DUT outputs of this cycle against one queued expectation.
  task automatic checkOutput(input exp_t e);
    logic [4:0] got;
    got = {stall_pc, stall_1, bubble_3, flush_2, freeze};
    tests_run++;
    if (got !== e.ctl) begin
      tests_failed++;
      $display("[TB] FAIL %s ctl {pc,s1,b3,f2,frz}: got %b expected %b", e.name, got, e.ctl);
    end
    tests_run++;
    if (mem_timeout !== e.timeout) begin
      tests_failed++;
      $display("[TB] FAIL %s Mem_Timeout: got %b expected %b", e.name, mem_timeout, e.timeout);
    end
    if (e.chk_cnt) begin
      tests_run++;
      if (stall_count !== e.stall_c) begin
        tests_failed++;
        $display("[TB] FAIL %s Stall_Count: got %0d expected %0d", e.name, stall_count, e.stall_c);
      end
      tests_run++;
      if (flush_count !== e.flush_c) begin
        tests_failed++;
        $display("[TB] FAIL %s Flush_Count: got %0d expected %0d", e.name, flush_count, e.flush_c);
      end
      tests_run++;
      if (freeze_count !== e.freeze_c) begin
        tests_failed++;
        $display("[TB] FAIL %s Freeze_Count: got %0d expected %0d", e.name, freeze_count, e.freeze_c);
      end
    end
  endtask

  // Monitor: every cycle the DUT presents its outputs, check the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  // Directed stimulus sequence.
  initial begin
    // name        rst rs1 rs2 u2 rd mr br rq rdy ec pc ctl      to chk S  F  Z
    applyStimulus("reset",     1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b00000, 0, 1, 0, 0, 0);
    applyStimulus("idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 1, 0, 0, 0);
    applyStimulus("lu_rs1",    0, 5, 0, 0, 5, 1, 0, 0, 0, 0, 0, 5'b11100, 0, 1, 0, 0, 0);
    applyStimulus("lu_after",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 1, 1, 0, 0);
    applyStimulus("rs2_nouse", 0, 0, 7, 0, 7, 1, 0, 0, 0, 0, 0, 5'b00000, 0, 1, 1, 0, 0);
    applyStimulus("rs2_use",   0, 0, 7, 1, 7, 1, 0, 0, 0, 0, 0, 5'b11100, 0, 1, 1, 0, 0);
    applyStimulus("rd_zero",   0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 5'b00000, 0, 1, 2, 0, 0);
    applyStimulus("pclear",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 0, 1, 2, 0, 0);
    applyStimulus("br_lu",     0, 5, 0, 0, 5, 1, 1, 0, 0, 0, 0, 5'b00110, 0, 1, 0, 0, 0);
    applyStimulus("br_after",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 1, 0, 1, 0);
    // Memory wait of three cycles, with a load-use hidden under the freeze.
    applyStimulus("mw_1",      0, 5, 0, 0, 5, 1, 0, 1, 0, 0, 0, 5'b00001, 0, 1, 0, 1, 0);
    applyStimulus("mw_2",      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b00001, 0, 0, 0, 0, 0);
    applyStimulus("mw_3",      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b00001, 0, 0, 0, 0, 0);
    applyStimulus("mw_ready",  0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 5'b00000, 0, 1, 0, 1, 3);
    applyStimulus("mw_run",    0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 5'b00110, 0, 1, 0, 1, 3);
    // Watchdog timeout after four waiting cycles.
    applyStimulus("to_1",      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b00001, 0, 1, 0, 2, 3);
    applyStimulus("to_2",      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b00001, 0, 0, 0, 0, 0);
    applyStimulus("to_3",      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b00001, 0, 0, 0, 0, 0);
    applyStimulus("to_4",      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b00001, 0, 0, 0, 0, 0);
    applyStimulus("err_late",  0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 5'b00001, 1, 0, 0, 0, 0);
    applyStimulus("err_br",    0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 5'b00001, 1, 0, 0, 0, 0);
    applyStimulus("err_clr",   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00001, 1, 0, 0, 0, 0);
    applyStimulus("err_done",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 1, 0, 2, 10);
    // Twenty flushes saturate the 4-bit flush counter.
    for (int i = 0; i < 20; i++)
      applyStimulus("flush_sat", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 5'b00110, 0, 0, 0, 0, 0);
    applyStimulus("sat_chk",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 1, 0, 15, 10);
    applyStimulus("clr_flush", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 5'b00110, 0, 1, 0, 15, 10);
    applyStimulus("clr_chk",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 1, 0, 0, 0);
    // Asynchronous reset in the middle of a wait.
    applyStimulus("rw_1",      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b00001, 0, 1, 0, 0, 0);
    applyStimulus("rw_2",      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b00001, 0, 1, 0, 0, 1);
    applyStimulus("rw_rst",    1, 5, 0, 0, 5, 1, 1, 1, 0, 0, 0, 5'b00000, 0, 1, 0, 0, 0);
    applyStimulus("rw_lu",     0, 5, 0, 0, 5, 1, 0, 0, 0, 0, 0, 5'b11100, 0, 1, 0, 0, 0);
    applyStimulus("rw_after",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 1, 1, 0, 0);

    // Let the monitor drain the queue, within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Pipeline hazard controller for the 5-stage RV32 core. It handles the hazards that operand forwarding cannot resolve: load-use stalls, taken-branch flushes, and data-memory wait freezes.
- Sits beside the EX-stage forwarding mux logic and drives the stall, bubble and flush controls of the PC, IF/ID, ID/EX and later pipeline registers.
- Holds a memory-wait state machine with a timeout watchdog, plus saturating performance counters.

Parameters:
- TIMEOUT, 16: consecutive memory-wait cycles before a timeout error. Legal range is 2 to 2^CNT_W-1.
- CNT_W, 16: width of the performance counters and the wait counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- RS1_2  in  5  rs1 of the instruction in ID.
- RS2_2  in  5  rs2 of the instruction in ID.
- Uses_RS2_2  in  1  ID instruction actually reads rs2.
- RD_3  in  5  rd of the instruction in EX.
- Mem_Read_3  in  1  EX instruction is a load.
- Branch_Taken_3  in  1  branch or jump resolved taken in EX.
- Mem_Req_4  in  1  MEM stage is issuing a data access.
- Mem_Ready_4  in  1  data memory completes the access this cycle.
- Err_Clear  in  1  clears the timeout error (synchronous).
- Perf_Clear  in  1  zeroes the performance counters (synchronous).
- Stall_PC  out  1  hold the PC.
- Stall_1  out  1  hold the IF/ID register.
- Bubble_3  out  1  load a NOP into ID/EX.
- Flush_2  out  1  squash the IF/ID contents.
- Freeze  out  1  hold every pipeline register.
- Mem_Timeout  out  1  sticky watchdog error.
- Stall_Count  out  CNT_W  load-use stall cycles.
- Flush_Count  out  CNT_W  branch flush events.
- Freeze_Count  out  CNT_W  memory freeze cycles.

Behaviour:
- Reset (async, rst high):
  - state=RUN, wait_cnt=0, Mem_Timeout=0, all counters 0.
  - While rst is high, all control outputs are 0.
- Definitions:
  - load_use = Mem_Read_3 && RD_3!=0 && (RD_3==RS1_2 || (Uses_RS2_2 && RD_3==RS2_2)).
  - mem_wait = Mem_Req_4 && !Mem_Ready_4.
- Control outputs are combinational from state and inputs (zero latency). Priority is Freeze > branch flush > load-use.
  - Freeze = (state==RUN && mem_wait) || (state==WAIT && !Mem_Ready_4) || state==ERROR.
  - Freeze high: Stall_PC, Stall_1, Bubble_3 and Flush_2 are all 0, since the frozen registers already hold.
  - Else if Branch_Taken_3: Flush_2=1, Bubble_3=1, Stall_PC=0 (PC takes the target). A coincident load_use is dropped because its instruction is squashed.
  - Else if load_use: Stall_PC=1, Stall_1=1, Bubble_3=1 for exactly one cycle. The next cycle the load is in MEM, so load_use clears by construction.
- FSM states: RUN, WAIT, ERROR.
  - RUN, mem_wait: go to WAIT, wait_cnt=1. Otherwise stay, wait_cnt=0.
  - WAIT, Mem_Ready_4: go to RUN, wait_cnt=0. That cycle Freeze=0 and the pipeline advances.
  - WAIT, !Mem_Ready_4: wait_cnt+1. If the incremented value equals TIMEOUT, go to ERROR and set Mem_Timeout=1.
  - ERROR: Freeze held at 1. Err_Clear returns to RUN with Mem_Timeout=0 and wait_cnt=0. Late Mem_Ready_4 is ignored.
  - Mem_Req_4 dropping while in WAIT is treated as ready (abort): return to RUN.
- Counters: saturate at 2^CNT_W-1. Perf_Clear has priority over increment in the same cycle.
  - Stall_Count: +1 per cycle where the load-use stall actually fires.
  - Flush_Count: +1 per cycle where Flush_2 is high.
  - Freeze_Count: +1 per cycle where Freeze is high.
- Reset mid-wait: immediate return to RUN, all registers cleared.
- RD_3=0 never creates a hazard.

Test Plan:
- Load-use on rs1: Mem_Read_3=1, RD_3=5, RS1_2=5 for one cycle -> Stall_PC=Stall_1=Bubble_3=1 that cycle, 0 the next; Stall_Count=1.
- rs2 hazard: RD_3=7=RS2_2. With Uses_RS2_2=0 -> no stall. With Uses_RS2_2=1 -> stall. With RD_3=0 -> never a stall.
- Branch flush: Branch_Taken_3=1 together with load_use -> Flush_2=1, Bubble_3=1, Stall_PC=0; Flush_Count=1, Stall_Count=0.
- Memory wait: Mem_Req_4=1, Mem_Ready_4 low for 3 cycles then high -> Freeze high exactly 3 cycles, state back in RUN; Freeze_Count=3, Mem_Timeout=0.
- Timeout (TIMEOUT=4): ready never asserted -> after the 4th freeze-cycle edge, state=ERROR and Mem_Timeout=1; later Mem_Ready_4 is ignored; Err_Clear -> RUN, Freeze=0.
- Counter saturation and clear (CNT_W=4): 20 flushes -> Flush_Count=15. Perf_Clear coincident with a flush -> 0. Async rst mid-WAIT -> all outputs 0 immediately.
